// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmit frame generator.
// The state encoding is also exported on the debug port of uart_tx_frame.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period up-counter for the transmitter. It asserts roll in the cycle
// whose closing edge is the limit-th edge of the current bit period.
module tx_bit_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         roll
);

  logic [W-1:0] count;

  // count holds the number of edges already spent in the bit. The edge that
  // would take it to limit is the rollover edge, so it wraps to 0 there.
  assign roll = en && (count == (limit - 1'b1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (roll) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Asynchronous serial transmitter: start bit, 8 data bits LSB first,
// optional even parity, one stop bit. tx_out is driven from a register.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       tx_done,
  output logic [2:0] fsm_state
);

  // Handshake: a frame is accepted on a rising edge where tx_start and
  // tx_ready are both high. tx_ready is high only in IDLE, and a tx_start
  // seen while tx_ready is low is dropped, never queued.

  localparam int             TW    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0]  LIMIT = TW'(CLKS_PER_BIT);
  localparam logic [2:0]     LAST  = 3'(DATA_BITS - 1);

  tx_state_t  state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic       par, par_n;
  logic       line_q, line_n;
  logic       done_q, done_n;
  logic       tmr_clr, tmr_en, roll;

  tx_bit_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .limit (LIMIT),
    .roll  (roll)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      line_q <= IDLE_LVL;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      shreg  <= shreg_n;
      par    <= par_n;
      line_q <= line_n;
      done_q <= done_n;
    end
  end

  // Each branch computes the level the line must show after the coming edge,
  // which makes the first line transition coincide with the accept edge.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    shreg_n = shreg;
    par_n   = par;
    line_n  = line_q;
    done_n  = 1'b0;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state)
      IDLE: begin
        line_n = IDLE_LVL;
        if (tx_start) begin
          shreg_n = tx_data;
          par_n   = even_parity(tx_data);
          line_n  = START_LVL;
          tmr_clr = 1'b1;
          state_n = START;
        end
      end
      START: begin
        tmr_en = 1'b1;
        if (roll) begin
          line_n  = shreg[0];
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        tmr_en = 1'b1;
        if (roll) begin
          if (idx == LAST) begin
            if (PARITY_EN != 0) begin
              line_n  = par;
              state_n = PARITY;
            end else begin
              line_n  = STOP_LVL;
              state_n = STOP;
            end
          end else begin
            shreg_n = {1'b0, shreg[7:1]};
            line_n  = shreg[1];
            idx_n   = idx + 3'd1;
          end
        end
      end
      PARITY: begin
        tmr_en = 1'b1;
        if (roll) begin
          line_n  = STOP_LVL;
          state_n = STOP;
        end
      end
      STOP: begin
        tmr_en = 1'b1;
        line_n = STOP_LVL;
        if (roll) begin
          line_n  = IDLE_LVL;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        line_n  = IDLE_LVL;
        state_n = IDLE;
      end
    endcase
  end

  assign tx_ready  = (state == IDLE);
  assign tx_out    = line_q;
  assign tx_done   = done_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three instances cover C=10 without and
// with parity and the C=2 corner; frames are checked against a bit-level model.
module tb_uart_tx_frame;
  import uart_tx_pkg::*;

  localparam int HN = 16384;
  localparam int CK [3] = '{10, 10, 2};
  localparam int PK [3] = '{0, 1, 0};

  logic       clk;
  logic       rst;
  logic [7:0] tdata  [3];
  logic       tstart [3];
  logic       tready [3];
  logic       tline  [3];
  logic       tdone  [3];
  logic [2:0] st     [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // {instance[1:0], accept edge[31:0], byte[7:0]}
  logic [41:0] exp_q[$];
  logic        hl [3][HN];
  logic        hr [3][HN];

  uart_tx_frame #(.CLKS_PER_BIT(10), .PARITY_EN(0)) u0 (
    .clk(clk), .rst(rst), .tx_data(tdata[0]), .tx_start(tstart[0]),
    .tx_ready(tready[0]), .tx_out(tline[0]), .tx_done(tdone[0]), .fsm_state(st[0]));
  uart_tx_frame #(.CLKS_PER_BIT(10), .PARITY_EN(1)) u1 (
    .clk(clk), .rst(rst), .tx_data(tdata[1]), .tx_start(tstart[1]),
    .tx_ready(tready[1]), .tx_out(tline[1]), .tx_done(tdone[1]), .fsm_state(st[1]));
  uart_tx_frame #(.CLKS_PER_BIT(2), .PARITY_EN(0)) u2 (
    .clk(clk), .rst(rst), .tx_data(tdata[2]), .tx_start(tstart[2]),
    .tx_ready(tready[2]), .tx_out(tline[2]), .tx_done(tdone[2]), .fsm_state(st[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: frame bit j of a byte (start, 8 data LSB first, parity, stop).
  function automatic logic frame_bit(input logic [7:0] b, input int j, input int par);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (j == 9 && par != 0) return ^b;
    return 1'b1;
  endfunction

  task automatic check_frame(input int k);
    logic [41:0] e;
    logic [7:0]  b;
    int a, n, c, errs, rerr, fj;
    if (exp_q.size() == 0) begin
      total++; bad++;
      $display("FAIL done_unexpected inst=%0d cyc=%0d got tx_done=1 required 0", k, cyc);
      return;
    end
    e = exp_q.pop_front();
    a = int'(e[39:8]);
    b = e[7:0];
    c = CK[k];
    n = (PK[k] != 0) ? 11 : 10;
    total++;
    if (int'(e[41:40]) != k || cyc != a + n * c) begin
      bad++;
      $display("FAIL done_time inst=%0d got edge %0d required %0d (exp inst %0d)",
               k, cyc, a + n * c, int'(e[41:40]));
    end
    errs = 0; fj = -1; rerr = 0;
    for (int j = 0; j < n * c; j++) begin
      if (hl[k][(a + j) % HN] !== frame_bit(b, j / c, PK[k])) begin
        errs++;
        if (fj < 0) fj = j;
      end
      if (hr[k][(a + j) % HN] !== 1'b0) rerr++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL frame_line inst=%0d byte=%02h got %0d wrong cycles (first at offset %0d) required 0",
               k, b, errs, fj);
    end
    total++;
    if (rerr != 0 || tready[k] !== 1'b1 || tline[k] !== 1'b1) begin
      bad++;
      $display("FAIL ready_window inst=%0d got %0d busy cycles with ready, ready_end=%b line_end=%b required 0,1,1",
               k, rerr, tready[k], tline[k]);
    end
  endtask

  // monitor: record line/ready history, check each frame when tx_done shows
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    for (int k = 0; k < 3; k++) begin
      hl[k][cyc % HN] = tline[k];
      hr[k][cyc % HN] = tready[k];
      if (tdone[k] === 1'b1) check_frame(k);
    end
  end

  // driver tasks
  task automatic send(input int k, input logic [7:0] b, input bit hold, output int a);
    int n;
    a = -1;
    n = 0;
    tdata[k]  = b;
    tstart[k] = 1'b1;
    while (a < 0 && n < 400) begin
      @(negedge clk);
      if (tready[k] === 1'b1) begin
        a = cyc + 1;
        exp_q.push_back({2'(k), 32'(a), b});
      end
      n++;
    end
    if (a < 0) begin
      total++; bad++;
      $display("FAIL accept_timeout inst=%0d got no accept in 400 cycles required accept", k);
    end
    @(posedge clk); #2;
    if (!hold) tstart[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input bit noise, input int a);
    int n, lim;
    n = 0;
    lim = a + ((PK[k] != 0) ? 11 : 10) * CK[k] - 2;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk); #2;
      n++;
      if (noise) begin
        tdata[k]  = 8'($urandom);
        tstart[k] = (cyc <= lim) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    tstart[k] = 1'b0;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout inst=%0d got %0d frames pending required 0", k, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int a, a2, rel, ierr;
    logic [7:0] b;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tdata[k] = 8'h00;
      tstart[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (tline[k] !== 1'b1 || tready[k] !== 1'b1 || tdone[k] !== 1'b0 || st[k] !== 3'(IDLE)) begin
        bad++;
        $display("FAIL reset_state inst=%0d got line=%b ready=%b done=%b state=%0d required 1,1,0,%0d",
                 k, tline[k], tready[k], tdone[k], st[k], 3'(IDLE));
      end
    end
    rst = 1'b0;

    for (int k = 0; k < 3; k++) begin
      ierr = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #2;
        if (tline[k] !== 1'b1 || tready[k] !== 1'b1 || tdone[k] !== 1'b0) ierr++;
      end
      total++;
      if (ierr != 0) begin
        bad++;
        $display("FAIL idle_hold inst=%0d got %0d bad idle cycles required 0", k, ierr);
      end
    end

    send(0, 8'hA5, 1'b0, a);
    wait_idle(0, 1'b0, a);
    send(1, 8'h07, 1'b0, a);
    wait_idle(1, 1'b0, a);

    // back-to-back with tx_start held; the second byte sits on tx_data all
    // through the first frame
    send(0, 8'h55, 1'b1, a);
    tdata[0] = 8'h0F;
    send(0, 8'h0F, 1'b0, a2);
    total++;
    if (a2 != a + 101) begin
      bad++;
      $display("FAIL b2b_gap got accept %0d required %0d", a2, a + 101);
    end
    wait_idle(0, 1'b0, a2);

    // reset in the middle of data bit 3
    send(0, 8'hA5, 1'b0, a);
    while (cyc < a + 45) begin
      @(posedge clk); #2;
    end
    total++;
    if (tline[0] !== frame_bit(8'hA5, 4, 0)) begin
      bad++;
      $display("FAIL pre_reset_line got %b required %b", tline[0], frame_bit(8'hA5, 4, 0));
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    total++;
    if (tline[0] !== 1'b1 || tready[0] !== 1'b1 || tdone[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got line=%b ready=%b done=%b required 1,1,0",
               tline[0], tready[0], tdone[0]);
    end
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    rel = cyc;
    send(0, 8'hFF, 1'b0, a);
    total++;
    if (a != rel + 1) begin
      bad++;
      $display("FAIL post_reset_accept got edge %0d required %0d", a, rel + 1);
    end
    wait_idle(0, 1'b0, a);

    send(2, 8'h00, 1'b0, a);
    wait_idle(2, 1'b0, a);

    // random bytes, random gaps, tx_data churn and dropped starts mid-frame
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #2;
        b = 8'($urandom);
        send(k, b, 1'b0, a);
        wait_idle(k, 1'b1, a);
      end
    end

    repeat (5) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish by 2ms required finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter that turns an 8-bit parallel byte into an asynchronous start/data/stop frame on a single line. It is the transmit-side counterpart to the lab's receiver datapath and sits between the byte-producing control logic and the serial output pin. Bit timing comes from an internal clock-divider counter with a programmable rollover, and an optional even-parity bit can be inserted.

## Interface
Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; legal range 2..1023.
- PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- tx_data  in  8  byte to send; sampled only on the accept cycle.
- tx_start  in  1  request; a frame is accepted when tx_start=1 and tx_ready=1 at a rising edge.
- tx_ready  out  1  high only in IDLE; combinational decode of state.
- tx_out  out  1  serial line, registered; idles high.
- tx_done  out  1  registered one-cycle pulse at frame completion.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. If tx_start is high, capture tx_data into the shift register, clear the bit timer, set tx_out=0, and go to START.
- START: hold tx_out=0 for CLKS_PER_BIT cycles. At timer rollover, drive tx_out=data[0], clear the bit index, and go to DATA.
- DATA: drive bits LSB first, each for CLKS_PER_BIT cycles. At each rollover, shift to the next bit. After bit 7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: drive the XOR of the 8 captured bits (even parity) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: drive tx_out=1 for CLKS_PER_BIT cycles. At rollover, go to IDLE and pulse tx_done.
- Bit timer: counts 1..CLKS_PER_BIT and strobes on reaching CLKS_PER_BIT. Width is $clog2(CLKS_PER_BIT+1).
- Bit index: 3 bits, counts 0..7, no wrap use.
- Changes to tx_data during a frame are ignored. tx_start while tx_ready=0 is dropped and not queued.
- Reset (tx_out, tx_done, tx_ready): tx_out=1, tx_done=0, tx_ready=1 (state IDLE).
- Reset (internals): timer=0, index=0, shift register=0.

## Timing
- Accept edge is edge A. tx_out=0 is visible from A through A+CLKS_PER_BIT.
- Data bit i is valid from A+(i+1)·C through A+(i+2)·C, where C = CLKS_PER_BIT.
- Frame length N is 10 bits, or 11 with parity. The stop bit ends at A+N·C.
- Completion: at edge A+N·C, the state returns to IDLE, tx_done=1 for exactly one cycle, and tx_ready=1.
- Back-to-back frames: tx_start held high continuously is accepted at edge A+N·C+1. The idle gap is therefore exactly 1 cycle of tx_out=1 beyond the stop bit.
- Reset asserted mid-frame: tx_out goes to 1 immediately (asynchronous) and no tx_done is issued. After release, the first rising edge with tx_start=1 is accepted.
- Latency from accept to the first line transition: 0 cycles after the accept edge, since tx_out is registered in the same edge.

## Structure
- Package uart_tx_pkg:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - constants DATA_BITS=8, START_LVL=1'b0, STOP_LVL=1'b1, IDLE_LVL=1'b1.
- Sub-module tx_bit_timer: parameterised-width up-counter with clear, enable, and rollover value, plus a one-cycle rollover strobe. Instantiate it once for bit timing; the 3-bit index stays inline.
- One registered FSM with a next-state always_comb. The shift register and parity bit are registered at accept.

## Test plan
- Reset, then idle 20 cycles: tx_out=1, tx_ready=1, tx_done=0 throughout.
- C=10, PARITY_EN=0, send 0xA5: tx_out bit sequence is 0,1,0,1,0,0,1,0,1,1, each bit held 10 cycles. tx_ready is low for 100 cycles and tx_done pulses once, at edge A+100.
- C=10, PARITY_EN=1, send 0x07: sequence 0,1,1,1,0,0,0,0,0,1(parity),1 with an 11-bit frame. tx_done comes at A+110.
- tx_start held high with 0x55 then 0x0F: the second start bit begins exactly 1 cycle after the first stop bit ends. Toggling tx_data mid-frame does not alter the line.
- Reset asserted at A+45 during data bit 3: tx_out=1 in the same cycle and no tx_done. A new send of 0xFF after release produces a correct full frame.
- C=2 corner, send 0x00: each bit lasts 2 cycles, the total frame is 20 cycles, and the pattern is 0×9 bits then a stop bit of 1.
